// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its consumers
// (colour source fetch side and the DAC/connector side).
interface vga_timing_gen_if;
   logic       pixel_tick;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       pixel_valid;
   logic       line_start;
   logic       frame_start;
   logic       VGA_CLK;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;
   logic       VGA_SYNC_N;

   modport master (
      output pixel_tick, pixel_x, pixel_y, pixel_valid, line_start, frame_start,
      output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
   );

   modport slave (
      input pixel_tick, pixel_x, pixel_y, pixel_valid, line_start, frame_start,
      input VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
   );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: CLOCK_50 / 2 pixel tick, x/y counters,
// sync/blank decode and a PIPE_DELAY-tick delay line matching colour fetch latency.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int PIPE_DELAY = 2      // legal range 0..8
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic blank_n;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

   logic       r_tick;
   logic [9:0] r_x;
   logic [9:0] r_y;
   logic       w_pixel_valid;
   sync_t      w_raw;
   sync_t      w_pipe_out;
   sync_t      r_out;
   logic       r_sync_n;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_tick <= 1'b0;
         r_x    <= '0;
         r_y    <= '0;
      end else begin
         r_tick <= ~r_tick;
         if (r_tick) begin
            if (r_x == 10'(H_TOTAL - 1)) begin
               r_x <= '0;
               r_y <= (r_y == 10'(V_TOTAL - 1)) ? '0 : r_y + 10'd1;
            end else begin
               r_x <= r_x + 10'd1;
            end
         end
      end
   end

   assign w_pixel_valid = (r_x < 10'(H_VISIBLE)) && (r_y < 10'(V_VISIBLE));

   always_comb begin
      // NOTE: whole struct defaulted first so no field can infer a latch.
      w_raw         = SYNC_IDLE;
      w_raw.hs_n    = !((r_x >= 10'(HS_START)) && (r_x < 10'(HS_END)));
      w_raw.vs_n    = !((r_y >= 10'(VS_START)) && (r_y < 10'(VS_END)));
      w_raw.blank_n = w_pixel_valid;
   end

   generate
      if (PIPE_DELAY == 0) begin : g_no_pipe
         assign w_pipe_out = w_raw;
      end else begin : g_pipe
         sync_t r_stage [PIPE_DELAY];

         // NOTE: delay stages are reset so no stale sync/blank leaks out before the pipe fills.
         always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
               for (int i = 0; i < PIPE_DELAY; i++) r_stage[i] <= SYNC_IDLE;
            end else if (r_tick) begin
               r_stage[0] <= w_raw;
               for (int i = 1; i < PIPE_DELAY; i++) r_stage[i] <= r_stage[i-1];
            end
         end

         assign w_pipe_out = r_stage[PIPE_DELAY-1];
      end
   endgenerate

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_out    <= SYNC_IDLE;
         r_sync_n <= 1'b0;
      end else begin
         r_sync_n <= 1'b0;
         if (r_tick) r_out <= w_pipe_out;
      end
   end

   assign vga.pixel_tick  = r_tick;
   assign vga.pixel_x     = r_x;
   assign vga.pixel_y     = r_y;
   assign vga.pixel_valid = w_pixel_valid;
   assign vga.line_start  = r_tick && (r_x == '0);
   assign vga.frame_start = r_tick && (r_x == '0) && (r_y == '0);
   // DAC clock is the tick flop itself: it falls on the edge the outputs change.
   assign vga.VGA_CLK     = r_tick;
   assign vga.VGA_HS      = r_out.hs_n;
   assign vga.VGA_VS      = r_out.vs_n;
   assign vga.VGA_BLANK_N = r_out.blank_n;
   assign vga.VGA_SYNC_N  = r_sync_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (16x8 pixels) with PIPE_DELAY 2 and 0;
// an arithmetic edge-count model is compared every cycle, plus directed literal checks.
module tb_vga_timing_gen;

   localparam int HV = 10, HF = 2, HS = 3, HB = 1;
   localparam int VV = 4,  VF = 1, VS = 2, VB = 1;
   localparam int HT = HV + HF + HS + HB;   // 16
   localparam int VT = VV + VF + VS + VB;   // 8
   localparam int FRAME = HT * VT;          // 128 pixels = 256 clocks

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int k;                 // CLOCK_50 edges since reset release
   bit cmp_en  = 1'b0;

   vga_timing_gen_if if_d2();
   vga_timing_gen_if if_d0();

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .PIPE_DELAY(2)
   ) u_dut_d2 (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .vga      (if_d2)
   );

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .PIPE_DELAY(0)
   ) u_dut_d0 (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .vga      (if_d0)
   );

   typedef struct {
      bit tick;
      int x;
      int y;
      bit valid;
      bit ls;
      bit fs;
      bit hs_n;
      bit vs_n;
      bit blank_n;
   } exp_t;

   // Pixel index = completed ticks mod frame; outputs show pixel (ticks - delay - 1).
   function automatic exp_t model(input int edges, input int delay);
      exp_t e;
      int t, p, q, qx, qy;
      t      = edges / 2;
      p      = t % FRAME;
      e.tick = (edges % 2) == 1;
      e.x    = p % HT;
      e.y    = p / HT;
      e.valid = (e.x < HV) && (e.y < VV);
      e.ls   = e.tick && (e.x == 0);
      e.fs   = e.ls && (e.y == 0);
      if (t > delay) begin
         q  = (t - delay - 1) % FRAME;
         qx = q % HT;
         qy = q / HT;
         e.hs_n    = !((qx >= HV + HF) && (qx < HV + HF + HS));
         e.vs_n    = !((qy >= VV + VF) && (qy < VV + VF + VS));
         e.blank_n = (qx < HV) && (qy < VV);
      end else begin
         e.hs_n    = 1'b1;
         e.vs_n    = 1'b1;
         e.blank_n = 1'b0;
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input string tag, input exp_t e,
                          input logic tick, input logic [9:0] x, input logic [9:0] y,
                          input logic valid, input logic ls, input logic fs,
                          input logic vclk, input logic hs, input logic vs,
                          input logic bn, input logic sn);
      check({tag, ".tick"},    32'(tick),  32'(e.tick));
      check({tag, ".x"},       32'(x),     32'(e.x));
      check({tag, ".y"},       32'(y),     32'(e.y));
      check({tag, ".valid"},   32'(valid), 32'(e.valid));
      check({tag, ".line_st"}, 32'(ls),    32'(e.ls));
      check({tag, ".frame_st"},32'(fs),    32'(e.fs));
      check({tag, ".vga_clk"}, 32'(vclk),  32'(e.tick));
      check({tag, ".hs"},      32'(hs),    32'(e.hs_n));
      check({tag, ".vs"},      32'(vs),    32'(e.vs_n));
      check({tag, ".blank_n"}, 32'(bn),    32'(e.blank_n));
      check({tag, ".sync_n"},  32'(sn),    32'd0);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp_dut("d2", model(k, 2), if_d2.pixel_tick, if_d2.pixel_x, if_d2.pixel_y,
                 if_d2.pixel_valid, if_d2.line_start, if_d2.frame_start, if_d2.VGA_CLK,
                 if_d2.VGA_HS, if_d2.VGA_VS, if_d2.VGA_BLANK_N, if_d2.VGA_SYNC_N);
         cmp_dut("d0", model(k, 0), if_d0.pixel_tick, if_d0.pixel_x, if_d0.pixel_y,
                 if_d0.pixel_valid, if_d0.line_start, if_d0.frame_start, if_d0.VGA_CLK,
                 if_d0.VGA_HS, if_d0.VGA_VS, if_d0.VGA_BLANK_N, if_d0.VGA_SYNC_N);
      end
   end

   int guard, c0, c1;
   int hs_low, vs_low, bn_hi2, bn_hi0, n_ls, n_fs, clk_hi, ls_first, ls_second, vs_y;

   initial begin
      rst_n  = 1'b0;
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.hs", 32'(if_d2.VGA_HS), 32'd1);
      check("rst.blank_n", 32'(if_d2.VGA_BLANK_N), 32'd0);

      // Release: first edge raises tick, frame_start visible immediately after.
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("first.frame_start", 32'(if_d2.frame_start), 32'd1);
      check("first.vga_clk", 32'(if_d2.VGA_CLK), 32'd1);
      check("first.x", 32'(if_d2.pixel_x), 32'd0);

      // HS falls 3 ticks (6 clocks) after pixel_x first shows sync start with PIPE_DELAY=2.
      guard = 0;
      while (!(if_d2.pixel_x == 10'(HV + HF)) && guard < 1000) begin @(negedge clk); guard++; end
      check("wait.x_sync_start", 32'(guard < 1000), 32'd1);
      c0 = 0;
      while (if_d2.VGA_HS !== 1'b0 && c0 < 1000) begin @(negedge clk); c0++; end
      check("hs.fall_latency", 32'(c0), 32'd6);

      // One full frame window starting on frame_start.
      guard = 0;
      @(negedge clk);
      while (!if_d2.frame_start && guard < 1000) begin @(negedge clk); guard++; end
      check("wait.frame_start", 32'(guard < 1000), 32'd1);
      hs_low = 0; vs_low = 0; bn_hi2 = 0; bn_hi0 = 0; n_ls = 0; n_fs = 0; clk_hi = 0;
      ls_first = -1; ls_second = -1; vs_y = -1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (!if_d2.VGA_HS) hs_low++;
         if (!if_d2.VGA_VS) begin
            if (vs_low == 0) vs_y = int'(if_d2.pixel_y);
            vs_low++;
         end
         if (if_d2.VGA_BLANK_N) bn_hi2++;
         if (if_d0.VGA_BLANK_N) bn_hi0++;
         if (if_d2.VGA_CLK) clk_hi++;
         if (if_d2.frame_start) n_fs++;
         if (if_d2.line_start) begin
            if (ls_first < 0) ls_first = i;
            else if (ls_second < 0) ls_second = i;
            n_ls++;
         end
         @(negedge clk);
      end
      check("frame.hs_low_clks", 32'(hs_low), 32'd48);
      check("frame.vs_low_clks", 32'(vs_low), 32'd64);
      check("frame.vs_start_line", 32'(vs_y), 32'd5);
      check("frame.blank_hi_d2", 32'(bn_hi2), 32'd80);
      check("frame.blank_hi_d0", 32'(bn_hi0), 32'd80);
      check("frame.vga_clk_hi", 32'(clk_hi), 32'd128);
      check("frame.line_starts", 32'(n_ls), 32'd8);
      check("frame.frame_starts", 32'(n_fs), 32'd1);
      check("line.period", 32'(ls_second - ls_first), 32'd32);

      // Wrap (15,7) -> (0,0) on one tick, frame_start on the following cycle.
      guard = 0;
      while (!(if_d2.pixel_x == 10'(HT - 1) && if_d2.pixel_y == 10'(VT - 1) && if_d2.pixel_tick)
             && guard < 1000) begin @(negedge clk); guard++; end
      check("wait.wrap", 32'(guard < 1000), 32'd1);
      @(posedge clk); #1;
      check("wrap.x", 32'(if_d2.pixel_x), 32'd0);
      check("wrap.y", 32'(if_d2.pixel_y), 32'd0);
      @(posedge clk); #1;
      check("wrap.frame_start", 32'(if_d2.frame_start), 32'd1);

      // Mid-line reset on line 2 takes effect without a clock edge.
      guard = 0;
      while (!(if_d2.pixel_x == 10'd5 && if_d2.pixel_y == 10'd2) && guard < 1000) begin
         @(negedge clk); guard++;
      end
      check("wait.midline", 32'(guard < 1000), 32'd1);
      check("pre_rst.blank_n", 32'(if_d2.VGA_BLANK_N), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("async.x", 32'(if_d2.pixel_x), 32'd0);
      check("async.y", 32'(if_d2.pixel_y), 32'd0);
      check("async.vga_clk", 32'(if_d2.VGA_CLK), 32'd0);
      check("async.hs", 32'(if_d2.VGA_HS), 32'd1);
      check("async.vs", 32'(if_d2.VGA_VS), 32'd1);
      check("async.blank_n_d2", 32'(if_d2.VGA_BLANK_N), 32'd0);
      check("async.blank_n_d0", 32'(if_d0.VGA_BLANK_N), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rerel.frame_start", 32'(if_d2.frame_start), 32'd1);
      check("rerel.x", 32'(if_d2.pixel_x), 32'd0);
      check("rerel.y", 32'(if_d2.pixel_y), 32'd0);

      // Two more frames under the per-cycle model comparison.
      repeat (4 * FRAME) @(negedge clk);
      cmp_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
